lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_op_enum.sv | 14 +
 rtl/lsu_load_align.sv | 35 +++
 rtl/lsu.sv | 131 +++++++++++++
 tb/tb_lsu.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_op_enum.sv
// Shared encodings for the load/store unit: access size codes and FSM states.
package lsu_op_enum;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Load formatter: picks the addressed byte/half lane of the bus word and extends it.
// Purely combinational.
module lsu_load_align
  import lsu_op_enum::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size_i,
  input  logic [1:0]      addr_lo_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      LSU_SIZE_B: rdata_o = {{(XLEN-8){~unsigned_i & byte_sel[7]}}, byte_sel};
      LSU_SIZE_H: rdata_o = {{(XLEN-16){~unsigned_i & half_sel[15]}}, half_sel};
      default:    rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding bus access, request -> grant -> response -> done pulse.
// Misaligned or illegal-size requests are rejected with a misalign pulse and never reach the bus.
module lsu
  import lsu_op_enum::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [1:0]      lsu_size_i,
  input  logic            lsu_unsigned_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_busy_o,
  output logic            lsu_done_o,
  output logic            lsu_misalign_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [3:0]      dbus_be_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i
);

  lsu_state_e      state_q, state_d;
  logic            we_q, uns_q, done_q, done_d, misalign_q, misalign_d;
  logic [1:0]      size_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, wdata_d, load_data;
  logic [3:0]      be_q, be_d;
  logic            aligned, accept;

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .unsigned_i (uns_q),
    .rdata_i    (dbus_rdata_i),
    .rdata_o    (load_data)
  );

  always_comb begin
    aligned = 1'b0;
    be_d    = 4'b1111;
    wdata_d = lsu_wdata_i;
    case (lsu_size_i)
      LSU_SIZE_B: begin
        aligned = 1'b1;
        be_d    = 4'b0001 << lsu_addr_i[1:0];
        wdata_d = {4{lsu_wdata_i[7:0]}};
      end
      LSU_SIZE_H: begin
        aligned = ~lsu_addr_i[0];
        be_d    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{lsu_wdata_i[15:0]}};
      end
      LSU_SIZE_W: aligned = (lsu_addr_i[1:0] == 2'b00);
      default:    aligned = 1'b0;
    endcase
  end

  // The done cycle is spent in IDLE, but a request is only taken once the pulse has gone.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    misalign_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lsu_req_i && !done_q) begin
          if (aligned) begin
            accept  = 1'b1;
            state_d = S_REQ;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      S_REQ:  if (dbus_gnt_i) state_d = S_WAIT;
      S_WAIT: begin
        if (dbus_rvalid_i) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      if (accept) begin
        we_q    <= lsu_we_i;
        uns_q   <= lsu_unsigned_i;
        size_q  <= lsu_size_i;
        addr_q  <= lsu_addr_i;
        be_q    <= be_d;
        wdata_q <= wdata_d;
      end
      if (done_d) rdata_q <= we_q ? '0 : load_data;
    end
  end

  assign lsu_busy_o     = (state_q != S_IDLE) || done_q;
  assign lsu_done_o     = done_q;
  assign lsu_misalign_o = misalign_q;
  assign lsu_rdata_o    = rdata_q;
  assign dbus_req_o     = (state_q == S_REQ);
  assign dbus_we_o      = we_q;
  assign dbus_addr_o    = {addr_q[XLEN-1:2], 2'b00};
  assign dbus_be_o      = be_q;
  assign dbus_wdata_o   = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed corner cases then randomized accesses against a lane-arithmetic model.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        lsu_req_i, lsu_we_i, lsu_unsigned_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_busy_o, lsu_done_o, lsu_misalign_o;
  logic [31:0] lsu_rdata_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  lsu #(.XLEN(32)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_unsigned_i (lsu_unsigned_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_busy_o     (lsu_busy_o),
    .lsu_done_o     (lsu_done_o),
    .lsu_misalign_o (lsu_misalign_o),
    .lsu_rdata_o    (lsu_rdata_o),
    .dbus_req_o     (dbus_req_o),
    .dbus_we_o      (dbus_we_o),
    .dbus_addr_o    (dbus_addr_o),
    .dbus_be_o      (dbus_be_o),
    .dbus_wdata_o   (dbus_wdata_o),
    .dbus_gnt_i     (dbus_gnt_i),
    .dbus_rvalid_i  (dbus_rvalid_i),
    .dbus_rdata_i   (dbus_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, {31'd0, lsu_busy_o}, 0);
    chk({tag, ".done"}, {31'd0, lsu_done_o}, 0);
    chk({tag, ".misalign"}, {31'd0, lsu_misalign_o}, 0);
    chk({tag, ".rdata"}, lsu_rdata_o, 0);
    chk({tag, ".dreq"}, {31'd0, dbus_req_o}, 0);
    chk({tag, ".dwe"}, {31'd0, dbus_we_o}, 0);
    chk({tag, ".daddr"}, dbus_addr_o, 0);
    chk({tag, ".dbe"}, {28'd0, dbus_be_o}, 0);
    chk({tag, ".dwdata"}, dbus_wdata_o, 0);
  endtask

  // Drive ignored-request noise while the unit is busy.
  task automatic poke_req(input logic en);
    lsu_req_i      = en;
    lsu_we_i       = 1'($urandom);
    lsu_size_i     = 2'b10;
    lsu_unsigned_i = 1'($urandom);
    lsu_addr_i     = $urandom & 32'hFFFF_FFFC;
    lsu_wdata_i    = $urandom;
  endtask

  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int gd, input int rd,
                        input logic poke);
    int          ofs;
    logic [31:0] e_addr, e_wd, e_rd, v;
    logic [3:0]  e_be;
    ofs    = int'(addr % 4);
    e_addr = addr - 32'(ofs);
    if (size == 2'd0) begin
      e_be = 4'(1 << ofs);
      e_wd = {24'd0, wdata[7:0]} * 32'h0101_0101;
      v    = (rdata >> (8 * ofs)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      e_be = 4'(3 << ofs);
      e_wd = {16'd0, wdata[15:0]} * 32'h0001_0001;
      v    = (rdata >> (8 * ofs)) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      e_be = 4'hF;
      e_wd = wdata;
      v    = rdata;
    end
    e_rd = we ? 32'd0 : v;

    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_unsigned_i = uns;
    lsu_addr_i = addr; lsu_wdata_i = wdata;
    step();
    poke_req(poke);
    for (int k = 0; k <= gd; k++) begin
      dbus_gnt_i    = (k == gd);
      dbus_rvalid_i = (k != gd) ? 1'($urandom) : 1'b0;
      dbus_rdata_i  = $urandom;
      chk("req.dreq", {31'd0, dbus_req_o}, 1);
      chk("req.busy", {31'd0, lsu_busy_o}, 1);
      chk("req.done", {31'd0, lsu_done_o}, 0);
      chk("req.daddr", dbus_addr_o, e_addr);
      chk("req.dbe", {28'd0, dbus_be_o}, {28'd0, e_be});
      chk("req.dwdata", dbus_wdata_o, e_wd);
      chk("req.dwe", {31'd0, dbus_we_o}, {31'd0, we});
      step();
    end
    dbus_gnt_i = 1'b0;
    chk("wait.dreq", {31'd0, dbus_req_o}, 0);
    for (int j = 0; j <= rd; j++) begin
      dbus_rvalid_i = (j == rd);
      dbus_rdata_i  = (j == rd) ? rdata : $urandom;
      chk("wait.busy", {31'd0, lsu_busy_o}, 1);
      chk("wait.done", {31'd0, lsu_done_o}, 0);
      step();
    end
    dbus_rvalid_i = 1'b0;
    poke_req(poke);
    chk("done.pulse", {31'd0, lsu_done_o}, 1);
    chk("done.busy", {31'd0, lsu_busy_o}, 1);
    chk("done.rdata", lsu_rdata_o, e_rd);
    chk("done.dreq", {31'd0, dbus_req_o}, 0);
    chk("done.misalign", {31'd0, lsu_misalign_o}, 0);
    step();
    lsu_req_i = 1'b0;
    chk("post.done", {31'd0, lsu_done_o}, 0);
    chk("post.busy", {31'd0, lsu_busy_o}, 0);
    chk("post.dreq", {31'd0, dbus_req_o}, 0);
  endtask

  task automatic reject(input logic [1:0] size, input logic [31:0] addr);
    lsu_req_i = 1'b1; lsu_we_i = 1'($urandom); lsu_size_i = size;
    lsu_unsigned_i = 1'($urandom); lsu_addr_i = addr; lsu_wdata_i = $urandom;
    step();
    lsu_req_i = 1'b0;
    chk("mis.pulse", {31'd0, lsu_misalign_o}, 1);
    chk("mis.dreq", {31'd0, dbus_req_o}, 0);
    chk("mis.busy", {31'd0, lsu_busy_o}, 0);
    chk("mis.done", {31'd0, lsu_done_o}, 0);
    step();
    chk("mis.once", {31'd0, lsu_misalign_o}, 0);
    chk("mis.dreq2", {31'd0, dbus_req_o}, 0);
    chk("mis.done2", {31'd0, lsu_done_o}, 0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    rst_n_i = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00;
    lsu_unsigned_i = 1'b0; lsu_addr_i = 32'd0; lsu_wdata_i = 32'd0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'd0;
    #2;
    chk_all_zero("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step();

    access(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    access(1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'd0, 32'h80AB_CDEF, 0, 0, 1'b0);
    chk("lb.sext", lsu_rdata_o, 32'hFFFF_FF80);
    access(1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'd0, 32'h80AB_CDEF, 0, 0, 1'b0);
    chk("lbu.zext", lsu_rdata_o, 32'h0000_0080);
    access(1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 0, 1'b0);
    reject(2'd2, 32'h0000_0101);
    reject(2'd1, 32'h0000_0203);
    reject(2'd3, 32'h0000_0200);
    access(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'd0, 32'h55AA_33CC, 5, 2, 1'b1);

    // Reset in WAIT abandons the access; a late response must not complete it.
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'd2; lsu_addr_i = 32'h0000_0300;
    step();
    lsu_req_i = 1'b0; dbus_gnt_i = 1'b1;
    step();
    dbus_gnt_i = 1'b0;
    chk("rst.inwait", {31'd0, lsu_busy_o}, 1);
    #2 rst_n_i = 1'b0;
    #1;
    chk_all_zero("rst.async");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h1111_2222;
    step();
    dbus_rvalid_i = 1'b0;
    chk_all_zero("rst.late");
    step();
    chk("rst.nodone", {31'd0, lsu_done_o}, 0);

    for (int n = 0; n < 200; n++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       reject(2'd3, a);
          1:       reject(2'd1, a | 32'd1);
          default: reject(2'd2, (a & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3)));
        endcase
      end else begin
        sz = 2'($urandom_range(0, 2));
        if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
        if (sz == 2'd2) a = a & 32'hFFFF_FFFC;
        access(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
